// File: rtl/citadel_fpu_arb_pkg.sv
// Shared types for the citadel FPU two-port arbiter: FPU command record,
// owner identifier and the default response-owner FIFO depth.
package citadel_fpu_arb_pkg;

  typedef struct packed {
    logic [7:0]  opcode;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] wdata;
  } citadel_fpu_cmd_req_struct;

  typedef logic citadel_arb_owner_t;

  localparam citadel_arb_owner_t OWNER_M0 = 1'b0;
  localparam citadel_arb_owner_t OWNER_M1 = 1'b1;

  localparam int CITADEL_ARB_TAG_DEPTH = 8;

endpackage

// File: rtl/citadel_fpu_arb_tag_fifo.sv
// Response-owner FIFO: remembers which requester issued each command that
// expects a response, in issue order. Power-of-two depth, pointers wrap.
module citadel_tag_fifo
  import citadel_fpu_arb_pkg::*;
#(
  parameter int DEPTH = CITADEL_ARB_TAG_DEPTH
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push_i,
  input  citadel_arb_owner_t wdata_i,
  input  logic               pop_i,
  output citadel_arb_owner_t rdata_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  citadel_arb_owner_t mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic               do_push;
  logic               do_pop;

  assign full_o  = (count == CW'(DEPTH));
  assign empty_o = (count == '0);

  // Push is judged against occupancy before any same-cycle pop.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata_i;
  end

  assign rdata_o = mem[rd_ptr];

endmodule

// File: rtl/citadel_fpu_arb.sv
// Two-port round-robin arbiter in front of one citadel_fpu: single issue
// register toward the FPU, in-order routing of responses to their owner.
module citadel_fpu_arb
  import citadel_fpu_arb_pkg::*;
#(
  parameter int TAG_DEPTH = CITADEL_ARB_TAG_DEPTH
) (
  input  logic                      clk_i,
  input  logic                      rst_i,

  input  logic                      m0_req_i,
  input  citadel_fpu_cmd_req_struct m0_cmd_bi,
  input  logic                      m0_resp_exp_i,
  output logic                      m0_ack_o,
  output logic                      m0_resp_o,
  output logic [31:0]               m0_rdata_bo,

  input  logic                      m1_req_i,
  input  citadel_fpu_cmd_req_struct m1_cmd_bi,
  input  logic                      m1_resp_exp_i,
  output logic                      m1_ack_o,
  output logic                      m1_resp_o,
  output logic [31:0]               m1_rdata_bo,

  output logic                      fpu_req_o,
  output citadel_fpu_cmd_req_struct fpu_cmd_bo,
  input  logic                      fpu_ack_i,
  input  logic                      fpu_resp_i,
  input  logic [31:0]               fpu_rdata_bi,
  output logic                      fpu_resp_ack_o,

  output logic                      err_o
);

  // Handshake rule on every port pair: a transfer happens in a cycle where
  // req and ack are both high; the requesting side holds req and its
  // payload stable until that cycle.

  logic                      iss_valid;
  citadel_fpu_cmd_req_struct iss_cmd;
  citadel_arb_owner_t        rr_last;

  logic                      can_load;
  logic                      elig0;
  logic                      elig1;
  logic                      grant0;
  logic                      grant1;
  logic                      grant_any;
  citadel_arb_owner_t        grant_owner;
  citadel_fpu_cmd_req_struct grant_cmd;
  logic                      grant_resp_exp;

  logic                      tag_push;
  logic                      tag_pop;
  citadel_arb_owner_t        tag_head;
  logic                      tag_full;
  logic                      tag_empty;

  // The issue register may refill in the same cycle the FPU takes it.
  assign can_load = !iss_valid || fpu_ack_i;

  assign elig0 = !rst_i && m0_req_i && can_load && !(m0_resp_exp_i && tag_full);
  assign elig1 = !rst_i && m1_req_i && can_load && !(m1_resp_exp_i && tag_full);

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (elig0 && elig1) begin
      if (rr_last == OWNER_M1) grant0 = 1'b1;
      else                     grant1 = 1'b1;
    end else begin
      grant0 = elig0;
      grant1 = elig1;
    end
  end

  assign grant_any      = grant0 || grant1;
  assign grant_owner    = grant1 ? OWNER_M1 : OWNER_M0;
  assign grant_cmd      = grant1 ? m1_cmd_bi : m0_cmd_bi;
  assign grant_resp_exp = grant1 ? m1_resp_exp_i : m0_resp_exp_i;

  assign m0_ack_o = grant0;
  assign m1_ack_o = grant1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      iss_valid <= 1'b0;
      iss_cmd   <= '0;
      rr_last   <= OWNER_M1;
    end else begin
      if (grant_any) begin
        iss_valid <= 1'b1;
        iss_cmd   <= grant_cmd;
        rr_last   <= grant_owner;
      end else if (fpu_ack_i) begin
        iss_valid <= 1'b0;
      end
    end
  end

  assign fpu_req_o  = iss_valid;
  assign fpu_cmd_bo = iss_cmd;

  // Owners are queued at grant time; the FPU answers in command order.
  assign tag_push = grant_any && grant_resp_exp;
  assign tag_pop  = fpu_resp_i && !tag_empty;

  citadel_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (tag_push),
    .wdata_i (grant_owner),
    .pop_i   (tag_pop),
    .rdata_o (tag_head),
    .full_o  (tag_full),
    .empty_o (tag_empty)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m0_resp_o   <= 1'b0;
      m1_resp_o   <= 1'b0;
      m0_rdata_bo <= '0;
      m1_rdata_bo <= '0;
      err_o       <= 1'b0;
    end else begin
      m0_resp_o <= tag_pop && (tag_head == OWNER_M0);
      m1_resp_o <= tag_pop && (tag_head == OWNER_M1);
      if (tag_pop && (tag_head == OWNER_M0)) m0_rdata_bo <= fpu_rdata_bi;
      if (tag_pop && (tag_head == OWNER_M1)) m1_rdata_bo <= fpu_rdata_bi;
      // A response with no queued owner is dropped and flagged until reset.
      if (fpu_resp_i && tag_empty) err_o <= 1'b1;
    end
  end

  assign fpu_resp_ack_o = 1'b1;

endmodule

// File: tb/tb_citadel_fpu_arb.sv
// Bench for citadel_fpu_arb: directed vector table, hand-written corner
// sequences and a random run checked against a queue-based reference model.
module tb_citadel_fpu_arb;
  import citadel_fpu_arb_pkg::*;

  localparam int DEPTH = 8;

  logic                      clk_gen = 1'b0;
  logic                      rst;
  logic                      m0_req_i, m0_resp_exp_i, m0_ack_o, m0_resp_o;
  logic                      m1_req_i, m1_resp_exp_i, m1_ack_o, m1_resp_o;
  citadel_fpu_cmd_req_struct m0_cmd_bi, m1_cmd_bi, fpu_cmd_bo;
  logic [31:0]               m0_rdata_bo, m1_rdata_bo, fpu_rdata_bi;
  logic                      fpu_req_o, fpu_ack_i, fpu_resp_i, fpu_resp_ack_o, err_o;

  always #5 clk_gen = ~clk_gen;

  citadel_fpu_arb #(.TAG_DEPTH(DEPTH)) dut (
    .clk_i          (clk_gen),
    .rst_i          (rst),
    .m0_req_i       (m0_req_i),
    .m0_cmd_bi      (m0_cmd_bi),
    .m0_resp_exp_i  (m0_resp_exp_i),
    .m0_ack_o       (m0_ack_o),
    .m0_resp_o      (m0_resp_o),
    .m0_rdata_bo    (m0_rdata_bo),
    .m1_req_i       (m1_req_i),
    .m1_cmd_bi      (m1_cmd_bi),
    .m1_resp_exp_i  (m1_resp_exp_i),
    .m1_ack_o       (m1_ack_o),
    .m1_resp_o      (m1_resp_o),
    .m1_rdata_bo    (m1_rdata_bo),
    .fpu_req_o      (fpu_req_o),
    .fpu_cmd_bo     (fpu_cmd_bo),
    .fpu_ack_i      (fpu_ack_i),
    .fpu_resp_i     (fpu_resp_i),
    .fpu_rdata_bi   (fpu_rdata_bi),
    .fpu_resp_ack_o (fpu_resp_ack_o),
    .err_o          (err_o)
  );

  // Reference model: pending issue slot, owner queue, last winner, outputs.
  logic                      mdl_iss_valid;
  citadel_fpu_cmd_req_struct mdl_iss_cmd;
  logic                      mdl_last;
  logic [0:0]                exp_q[$];
  logic                      mdl_err;
  logic                      mdl_resp [2];
  logic [31:0]               mdl_rdata [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic g0_x, g1_x;

  typedef struct {
    logic rst, m0r, m0e, m1r, m1e, fa, fr;
    logic [31:0] rd;
    logic a0, a1, fq, p0, p1;
    logic [31:0] rdx;
    logic er;
  } vec_t;

  vec_t tbl[$];

  citadel_fpu_cmd_req_struct cmd_a, cmd_b, cmd_x, cmd_y, cmd_z;

  function automatic vec_t v(input logic r, m0r, m0e, m1r, m1e, fa, fr,
                             input logic [31:0] rd,
                             input logic a0, a1, fq, p0, p1,
                             input logic [31:0] rdx, input logic er);
    return '{r, m0r, m0e, m1r, m1e, fa, fr, rd, a0, a1, fq, p0, p1, rdx, er};
  endfunction

  function automatic citadel_fpu_cmd_req_struct rnd_cmd();
    citadel_fpu_cmd_req_struct c;
    c.opcode  = 8'($urandom);
    c.rf_we   = 1'($urandom);
    c.rf_addr = 5'($urandom);
    c.wdata   = $urandom;
    return c;
  endfunction

  task automatic model_reset();
    mdl_iss_valid = 1'b0;
    mdl_iss_cmd   = '0;
    mdl_last      = 1'b1;
    exp_q.delete();
    mdl_err       = 1'b0;
    mdl_resp[0]   = 1'b0;
    mdl_resp[1]   = 1'b0;
    mdl_rdata[0]  = '0;
    mdl_rdata[1]  = '0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  // One clock: drive at negedge, compare #1 later, then advance the model.
  task automatic step(input logic r, r0, e0, r1, e1, fa, fr, input logic [31:0] rd,
                      input citadel_fpu_cmd_req_struct c0, c1);
    logic el0, el1, w0, w1;
    logic [0:0] who;
    @(negedge clk_gen);
    cyc++;
    rst = r; m0_req_i = r0; m0_resp_exp_i = e0; m0_cmd_bi = c0;
    m1_req_i = r1; m1_resp_exp_i = e1; m1_cmd_bi = c1;
    fpu_ack_i = fa; fpu_resp_i = fr; fpu_rdata_bi = rd;
    if (r) model_reset();
    el0 = !r && r0 && (!mdl_iss_valid || fa) && !(e0 && exp_q.size() >= DEPTH);
    el1 = !r && r1 && (!mdl_iss_valid || fa) && !(e1 && exp_q.size() >= DEPTH);
    w0  = el0 && (!el1 || mdl_last == 1'b1);
    w1  = el1 && (!el0 || mdl_last == 1'b0);
    #1;
    chk("m0_ack", 64'(m0_ack_o), 64'(w0));
    chk("m1_ack", 64'(m1_ack_o), 64'(w1));
    chk("fpu_req", 64'(fpu_req_o), 64'(mdl_iss_valid));
    if (mdl_iss_valid) chk("fpu_cmd", 64'(fpu_cmd_bo), 64'(mdl_iss_cmd));
    chk("m0_resp", 64'(m0_resp_o), 64'(mdl_resp[0]));
    chk("m1_resp", 64'(m1_resp_o), 64'(mdl_resp[1]));
    chk("m0_rdata", 64'(m0_rdata_bo), 64'(mdl_rdata[0]));
    chk("m1_rdata", 64'(m1_rdata_bo), 64'(mdl_rdata[1]));
    chk("err", 64'(err_o), 64'(mdl_err));
    chk("resp_ack", 64'(fpu_resp_ack_o), 64'(1));
    g0_x = w0;
    g1_x = w1;
    if (!r) begin
      mdl_resp[0] = 1'b0;
      mdl_resp[1] = 1'b0;
      if (fr) begin
        if (exp_q.size() > 0) begin
          who = exp_q.pop_front();
          mdl_resp[who]  = 1'b1;
          mdl_rdata[who] = rd;
        end else begin
          mdl_err = 1'b1;
        end
      end
      if (w0 && e0) exp_q.push_back(1'b0);
      if (w1 && e1) exp_q.push_back(1'b1);
      if (w0) begin
        mdl_iss_valid = 1'b1; mdl_iss_cmd = c0; mdl_last = 1'b0;
      end else if (w1) begin
        mdl_iss_valid = 1'b1; mdl_iss_cmd = c1; mdl_last = 1'b1;
      end else if (fa) begin
        mdl_iss_valid = 1'b0;
      end
    end
  endtask

  task automatic idle(input logic fa, fr, input logic [31:0] rd);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, fa, fr, rd, cmd_a, cmd_b);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, cmd_a, cmd_b);
  endtask

  initial begin
    logic pend0, pend1, pe0, pe1, rr, ff, fr;
    citadel_fpu_cmd_req_struct pc0, pc1;

    rst = 1'b1;
    m0_req_i = 1'b0; m0_resp_exp_i = 1'b0; m0_cmd_bi = '0;
    m1_req_i = 1'b0; m1_resp_exp_i = 1'b0; m1_cmd_bi = '0;
    fpu_ack_i = 1'b0; fpu_resp_i = 1'b0; fpu_rdata_bi = '0;
    model_reset();

    cmd_a = '{opcode: 8'h10, rf_we: 1'b1, rf_addr: 5'd3, wdata: 32'h1111_0003};
    cmd_b = '{opcode: 8'h22, rf_we: 1'b0, rf_addr: 5'd9, wdata: 32'h2222_0009};
    cmd_x = '{opcode: 8'h31, rf_we: 1'b1, rf_addr: 5'd7, wdata: 32'hDEAD_BEEF};
    cmd_y = '{opcode: 8'h42, rf_we: 1'b1, rf_addr: 5'd1, wdata: 32'h0BAD_F00D};
    cmd_z = '{opcode: 8'h53, rf_we: 1'b0, rf_addr: 5'd2, wdata: 32'hCAFE_0002};

    // Single command, contention with in-order responses, orphan response.
    tbl.push_back(v(1,0,0,0,0,0,0,0,  0,0,0,0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,1,0,0,  1,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,1,0,0,  0,0,1,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,1,0,0,  0,0,0,0,0,0,0));
    tbl.push_back(v(1,0,0,0,0,0,0,0,  0,0,0,0,0,0,0));
    for (int k = 0; k < 7; k++)
      tbl.push_back(v(0,1,1,1,1,1,0,0, 1'(k % 2 == 0), 1'(k % 2 == 1), 1'(k != 0), 0,0,0,0));
    tbl.push_back(v(0,0,0,1,1,1,0,0,  0,1,1,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,1,0,0,  0,0,1,0,0,0,0));
    for (int k = 0; k < 9; k++)
      tbl.push_back(v(0,0,0,0,0,1, 1'(k < 8), 32'(32'hA0 + k), 0,0,0,
                      1'(k > 0 && (k - 1) % 2 == 0), 1'(k > 0 && (k - 1) % 2 == 1),
                      32'(32'hA0 + k - 1), 0));
    tbl.push_back(v(0,0,0,0,0,1,1,32'h55, 0,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,1,0,0,      0,0,0,0,0,0,1));

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].m0r, tbl[i].m0e, tbl[i].m1r, tbl[i].m1e,
           tbl[i].fa, tbl[i].fr, tbl[i].rd, cmd_a, cmd_b);
      chk("tbl_m0_ack", 64'(m0_ack_o), 64'(tbl[i].a0));
      chk("tbl_m1_ack", 64'(m1_ack_o), 64'(tbl[i].a1));
      chk("tbl_fpu_req", 64'(fpu_req_o), 64'(tbl[i].fq));
      chk("tbl_m0_resp", 64'(m0_resp_o), 64'(tbl[i].p0));
      chk("tbl_m1_resp", 64'(m1_resp_o), 64'(tbl[i].p1));
      chk("tbl_err", 64'(err_o), 64'(tbl[i].er));
      if (tbl[i].p0) chk("tbl_m0_rdata", 64'(m0_rdata_bo), 64'(tbl[i].rdx));
      if (tbl[i].p1) chk("tbl_m1_rdata", 64'(m1_rdata_bo), 64'(tbl[i].rdx));
      if (tbl[i].fq && i == 2) chk("tbl_cmd_a", 64'(fpu_cmd_bo), 64'(cmd_a));
    end

    // Back-pressure: FPU stalls five cycles, then takes the command and the
    // waiting requester is granted in that same cycle.
    do_reset();
    step(0, 1, 0, 0, 0, 0, 0, 0, cmd_x, cmd_b);
    chk("bp_first_ack", 64'(m0_ack_o), 64'(1));
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 0, 1, 0, 0, 0, 0, cmd_y, cmd_z);
      chk("bp_no_ack0", 64'(m0_ack_o), 64'(0));
      chk("bp_no_ack1", 64'(m1_ack_o), 64'(0));
      chk("bp_req_held", 64'(fpu_req_o), 64'(1));
      chk("bp_cmd_held", 64'(fpu_cmd_bo), 64'(cmd_x));
    end
    step(0, 1, 0, 1, 0, 1, 0, 0, cmd_y, cmd_z);
    chk("bp_release_ack1", 64'(m1_ack_o), 64'(1));
    idle(1, 0, 0);
    chk("bp_next_cmd", 64'(fpu_cmd_bo), 64'(cmd_z));

    // Owner FIFO full: resp_exp stalls, a resp_exp=0 command still issues.
    do_reset();
    for (int k = 0; k < DEPTH; k++) begin
      step(0, 1, 1, 0, 0, 1, 0, 0, cmd_a, cmd_b);
      chk("full_fill_ack", 64'(m0_ack_o), 64'(1));
    end
    step(0, 1, 1, 1, 0, 1, 0, 0, cmd_a, cmd_b);
    chk("full_stall", 64'(m0_ack_o), 64'(0));
    chk("full_bypass", 64'(m1_ack_o), 64'(1));
    step(0, 1, 1, 0, 0, 1, 1, 32'h77, cmd_a, cmd_b);
    chk("full_still_stalled", 64'(m0_ack_o), 64'(0));
    step(0, 1, 1, 0, 0, 1, 0, 0, cmd_a, cmd_b);
    chk("full_release", 64'(m0_ack_o), 64'(1));
    chk("full_resp_data", 64'(m0_rdata_bo), 64'(32'h77));

    // Reset mid-operation with a held command and three owners pending.
    do_reset();
    for (int k = 0; k < 3; k++) step(0, 1, 1, 0, 0, 1, 0, 0, cmd_a, cmd_b);
    step(0, 1, 0, 0, 0, 0, 0, 0, cmd_y, cmd_b);
    idle(0, 0, 0);
    chk("mid_req_before", 64'(fpu_req_o), 64'(1));
    @(posedge clk_gen);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_req", 64'(fpu_req_o), 64'(0));
    chk("mid_rst_cmd", 64'(fpu_cmd_bo), 64'(0));
    chk("mid_rst_resp", 64'({m0_resp_o, m1_resp_o}), 64'(0));
    chk("mid_rst_rdata", 64'({m0_rdata_bo, m1_rdata_bo}), 64'(0));
    chk("mid_rst_err", 64'(err_o), 64'(0));
    do_reset();
    step(0, 1, 0, 1, 0, 1, 0, 0, cmd_a, cmd_b);
    chk("mid_rr_m0", 64'(m0_ack_o), 64'(1));
    chk("mid_rr_m1", 64'(m1_ack_o), 64'(0));
    idle(1, 1, 32'h99);
    idle(1, 0, 0);
    chk("mid_stale_err", 64'(err_o), 64'(1));
    chk("mid_stale_no_resp", 64'({m0_resp_o, m1_resp_o}), 64'(0));

    // Random traffic against the model.
    do_reset();
    pend0 = 1'b0; pend1 = 1'b0; pe0 = 1'b0; pe1 = 1'b0;
    pc0 = '0; pc1 = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!pend0 && $urandom_range(0, 2) == 0) begin
        pend0 = 1'b1; pe0 = 1'($urandom_range(0, 1)); pc0 = rnd_cmd();
      end
      if (!pend1 && $urandom_range(0, 2) == 0) begin
        pend1 = 1'b1; pe1 = 1'($urandom_range(0, 1)); pc1 = rnd_cmd();
      end
      ff = 1'($urandom_range(0, 3) != 0);
      fr = (exp_q.size() > 0) ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 60) == 0);
      rr = 1'($urandom_range(0, 300) == 0);
      step(rr, pend0, pe0, pend1, pe1, ff, fr, $urandom, pc0, pc1);
      if (g0_x) pend0 = 1'b0;
      if (g1_x) pend1 = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
